// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_pkg
// Brief    : Shared MCU constants: instruction width, image header byte and
//            the loader state encoding.
// Revision : 1.0
// ============================================================================
package program_loader_pkg;

    localparam int          c_INSTR_W  = 18;
    localparam logic [7:0]  c_HDR_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LEN   = 4'd1,
        ST_B0    = 4'd2,
        ST_B1    = 4'd3,
        ST_B2    = 4'd4,
        ST_WRITE = 4'd5,
        ST_CHK   = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Byte-stream image loader: header, length, 3-byte instruction words
//            and an additive checksum; writes instruction memory and releases
//            the MCU core from reset once the image verifies.
// Revision : 1.0
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = c_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               mcu_reset,
    output logic               done,
    output logic               err
);

    ld_state_t          r_state_q, w_state_d;
    logic [ADDR_W-1:0]  r_addr_q,  w_addr_d;
    logic [7:0]         r_cnt_q,   w_cnt_d;
    logic [7:0]         r_wr_q,    w_wr_d;
    logic [7:0]         r_sum_q,   w_sum_d;
    logic [1:0]         r_b0_q,    w_b0_d;
    logic [7:0]         r_b1_q,    w_b1_d;
    logic [INSTR_W-1:0] r_wdata_q, w_wdata_d;
    logic               r_we_q,    w_we_d;
    logic               r_rdy_q,   w_rdy_d;
    logic               r_mrst_q,  w_mrst_d;
    logic               r_done_q,  w_done_d;
    logic               r_err_q,   w_err_d;

    logic               w_acc;
    logic [7:0]         w_wr_inc;

    assign w_acc    = in_valid && r_rdy_q;
    assign w_wr_inc = r_wr_q + 8'd1;

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_cnt_d   = r_cnt_q;
        w_wr_d    = r_wr_q;
        w_sum_d   = r_sum_q;
        w_b0_d    = r_b0_q;
        w_b1_d    = r_b1_q;
        w_wdata_d = r_wdata_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_acc && in_data == c_HDR_BYTE) w_state_d = ST_LEN;
            end
            ST_LEN: begin
                if (w_acc) begin
                    w_cnt_d   = in_data;
                    w_sum_d   = in_data;
                    w_addr_d  = '0;
                    w_wr_d    = 8'd0;
                    w_state_d = (in_data == 8'd0) ? ST_ERR : ST_B0;
                end
            end
            ST_B0: begin
                if (w_acc) begin
                    w_b0_d    = in_data[1:0];
                    w_sum_d   = r_sum_q + in_data;
                    w_state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (w_acc) begin
                    w_b1_d    = in_data;
                    w_sum_d   = r_sum_q + in_data;
                    w_state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (w_acc) begin
                    w_wdata_d = INSTR_W'({r_b0_q, r_b1_q, in_data});
                    w_sum_d   = r_sum_q + in_data;
                    w_state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address advances on leaving WRITE so it is stable during the strobe.
                w_addr_d  = r_addr_q + ADDR_W'(1);
                w_wr_d    = w_wr_inc;
                w_state_d = (w_wr_inc < r_cnt_q) ? ST_B0 : ST_CHK;
            end
            ST_CHK: begin
                if (w_acc) w_state_d = (in_data == r_sum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                w_state_d = ST_DONE;
            end
            ST_ERR: begin
                if (w_acc && in_data == c_HDR_BYTE) w_state_d = ST_LEN;
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        w_we_d   = (w_state_d == ST_WRITE);
        w_rdy_d  = !((w_state_d == ST_WRITE) || (w_state_d == ST_DONE));
        w_mrst_d = (w_state_d != ST_DONE);
        w_done_d = (w_state_d == ST_DONE);
        w_err_d  = (w_state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_cnt_q   <= 8'd0;
            r_wr_q    <= 8'd0;
            r_sum_q   <= 8'd0;
            r_b0_q    <= 2'd0;
            r_b1_q    <= 8'd0;
            r_wdata_q <= '0;
            r_we_q    <= 1'b0;
            r_rdy_q   <= 1'b1;
            r_mrst_q  <= 1'b1;
            r_done_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_cnt_q   <= w_cnt_d;
            r_wr_q    <= w_wr_d;
            r_sum_q   <= w_sum_d;
            r_b0_q    <= w_b0_d;
            r_b1_q    <= w_b1_d;
            r_wdata_q <= w_wdata_d;
            r_we_q    <= w_we_d;
            r_rdy_q   <= w_rdy_d;
            r_mrst_q  <= w_mrst_d;
            r_done_q  <= w_done_d;
            r_err_q   <= w_err_d;
        end
    end

    // Reset gates the strobe so a write pending in WRITE never reaches memory.
    assign imem_we    = r_we_q && !reset;
    assign imem_addr  = r_addr_q;
    assign imem_wdata = r_wdata_q;
    assign in_ready   = r_rdy_q;
    assign mcu_reset  = r_mrst_q;
    assign done       = r_done_q;
    assign err        = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Table-driven image loads with a write scoreboard, plus hand-written
//            reset sequences for mid-word and in-WRITE resets.
// Revision : 1.0
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [17:0] imem_wdata;
    logic        mcu_reset;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int n_wr_seen = 0;

    typedef struct {
        logic [7:0]  a;
        logic [17:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        bit          do_rst;
        bit          bp;
        int          nb;
        logic [7:0]  b[12];
        int          nw;
        logic [7:0]  wa[2];
        logic [17:0] wd[2];
        logic        x_done;
        logic        x_err;
    } vec_t;
    vec_t tbl[7];

    program_loader #(.ADDR_W(8), .INSTR_W(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .mcu_reset  (mcu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            n_wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.a || imem_wdata !== e.d) begin
                    failures++;
                    $display("FAIL write actual=%0h:%0h required=%0h:%0h", imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Presents one byte and returns right after the edge that transfers it.
    task automatic send(input logic [7:0] b, input bit bp);
        int t;
        if (bp) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a, input logic [17:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic send_nominal(input bit bp);
        logic [7:0] img[9];
        img = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'hE5};
        for (int k = 0; k < 9; k++) send(img[k], bp);
    endtask

    initial begin
        // Checksum = N + every payload byte, mod 256: 02+01+23+45+02+AB+CD = E5.
        tbl[0].do_rst = 1; tbl[0].bp = 0; tbl[0].nb = 9;
        tbl[0].b  = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'hE5, 8'h00, 8'h00, 8'h00};
        tbl[0].nw = 2; tbl[0].wa = '{8'h00, 8'h01}; tbl[0].wd = '{18'h12345, 18'h2ABCD};
        tbl[0].x_done = 1; tbl[0].x_err = 0;

        tbl[1] = tbl[0];
        tbl[1].b[8] = 8'hE4; tbl[1].x_done = 0; tbl[1].x_err = 1;

        tbl[2].do_rst = 1; tbl[2].bp = 0; tbl[2].nb = 2;
        tbl[2].b  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].nw = 0; tbl[2].wa = '{8'h00, 8'h00}; tbl[2].wd = '{18'h0, 18'h0};
        tbl[2].x_done = 0; tbl[2].x_err = 1;

        // Recovery straight out of ERR, no reset in between.
        tbl[3].do_rst = 0; tbl[3].bp = 0; tbl[3].nb = 6;
        tbl[3].b  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3].nw = 1; tbl[3].wa = '{8'h00, 8'h00}; tbl[3].wd = '{18'h00007, 18'h0};
        tbl[3].x_done = 1; tbl[3].x_err = 0;

        tbl[4].do_rst = 1; tbl[4].bp = 1; tbl[4].nb = 11;
        tbl[4].b  = '{8'h3C, 8'hFF, 8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'hE5, 8'h00};
        tbl[4].nw = 2; tbl[4].wa = '{8'h00, 8'h01}; tbl[4].wd = '{18'h12345, 18'h2ABCD};
        tbl[4].x_done = 1; tbl[4].x_err = 0;

        tbl[5].do_rst = 1; tbl[5].bp = 0; tbl[5].nb = 3;
        tbl[5].b  = '{8'hA5, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[5].nw = 0; tbl[5].wa = '{8'h00, 8'h00}; tbl[5].wd = '{18'h0, 18'h0};
        tbl[5].x_done = 0; tbl[5].x_err = 1;

        tbl[6].do_rst = 1; tbl[6].bp = 0; tbl[6].nb = 2;
        tbl[6].b  = '{8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[6].nw = 0; tbl[6].wa = '{8'h00, 8'h00}; tbl[6].wd = '{18'h0, 18'h0};
        tbl[6].x_done = 0; tbl[6].x_err = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_imem_we",    imem_we,    0);
        chk("rst_imem_addr",  imem_addr,  0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_mcu_reset",  mcu_reset,  1);
        chk("rst_done",       done,       0);
        chk("rst_err",        err,        0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_rst) apply_reset();
            n_wr_seen = 0;
            for (int k = 0; k < tbl[i].nw; k++) push(tbl[i].wa[k], tbl[i].wd[k]);
            for (int k = 0; k < tbl[i].nb; k++) send(tbl[i].b[k], tbl[i].bp);
            settle();
            chk($sformatf("v%0d_done", i),      done,      tbl[i].x_done);
            chk($sformatf("v%0d_err", i),       err,       tbl[i].x_err);
            chk($sformatf("v%0d_mcu_reset", i), mcu_reset, !tbl[i].x_done);
            chk($sformatf("v%0d_in_ready", i),  in_ready,  !tbl[i].x_done);
            chk($sformatf("v%0d_writes", i),    n_wr_seen, tbl[i].nw);
            chk($sformatf("v%0d_pending", i),   exp_q.size(), 0);
            exp_q.delete();
        end

        // Reset after B1 of word 1, with a byte offered in the reset cycle.
        apply_reset();
        n_wr_seen = 0;
        push(8'h00, 18'h12345);
        send(8'hA5, 0); send(8'h02, 0); send(8'h01, 0); send(8'h23, 0);
        send(8'h45, 0); send(8'h02, 0); send(8'hAB, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        reset    = 1'b1;
        @(negedge clk);
        chk("midword_in_ready", in_ready,  1);
        chk("midword_addr",     imem_addr, 0);
        chk("midword_done",     done,      0);
        chk("midword_err",      err,       0);
        chk("midword_writes",   n_wr_seen, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midword_no_write", n_wr_seen, 1);
        push(8'h00, 18'h12345);
        push(8'h01, 18'h2ABCD);
        send_nominal(0);
        settle();
        chk("reload_done",      done,      1);
        chk("reload_mcu_reset", mcu_reset, 0);
        chk("reload_writes",    n_wr_seen, 3);
        chk("reload_pending",   exp_q.size(), 0);
        exp_q.delete();

        // Reset raised during WRITE: the strobe must never appear.
        apply_reset();
        n_wr_seen = 0;
        send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0); send(8'h23, 0); send(8'h45, 0);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("wreset_writes",   n_wr_seen, 0);
        chk("wreset_in_ready", in_ready,  1);
        chk("wreset_addr",     imem_addr, 0);
        chk("wreset_wdata",    imem_wdata, 0);
        chk("wreset_mcu_rst",  mcu_reset, 1);
        repeat (3) @(negedge clk);
        chk("wreset_idle_we",  n_wr_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
